// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the pipeline request/response handshake and the data-memory bus of
// the load/store unit.
//   slave  modport : the load/store unit itself
//   master modport : the environment (pipeline + data memory)
// Pipeline side : reqValid/reqReady handshake, reqStore, reqFunct3,
//                 reqAddress, reqData, respValid, respData, respFault
// Memory side   : address, storeData, byteEnable, storeValid,
//                 loadData, loadDataValid, storeComplete
// ---------------------------------------------------------------------------
interface load_store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqStore;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddress;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic        respFault;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
    logic        storeValid;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;

    modport slave (
        input  reqValid, reqStore, reqFunct3, reqAddress, reqData,
        input  loadData, loadDataValid, storeComplete,
        output reqReady, respValid, respData, respFault,
        output address, storeData, byteEnable, storeValid
    );

    modport master (
        output reqValid, reqStore, reqFunct3, reqAddress, reqData,
        output loadData, loadDataValid, storeComplete,
        input  reqReady, respValid, respData, respFault,
        input  address, storeData, byteEnable, storeValid
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// RV32I load/store unit: accepts one request at a time from the pipeline,
// performs a word-aligned memory access with byte lanes, sign/zero-extends
// load results and returns a one-cycle response. Misaligned accesses,
// illegal width codes and memory timeouts return respFault.
// Ports:
//   clock  : single clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : load_store_unit_if.slave (pipeline handshake + memory bus)
// Parameter:
//   TIMEOUT_CYCLES : cycles waited for loadDataValid / storeComplete
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_ISSUE,
        STORE_WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [2:0]     req_funct3;
    logic [1:0]     req_offset;
    logic [CW-1:0]  wait_count;
    logic           request_legal;
    logic [31:0]    lane_data;
    logic [3:0]     lane_enable;
    logic [31:0]    load_shifted;
    logic [31:0]    load_result;
    logic           accept;

    // Ready falls with reset itself so nothing is accepted while held, and
    // rises in the first cycle after release without waiting for an edge.
    assign bus.reqReady = (state == IDLE) && reset;
    assign accept       = bus.reqValid && bus.reqReady;

    // Width code legality and natural alignment; BU/HU exist only for loads.
    always_comb begin
        request_legal = 1'b0;
        case (bus.reqFunct3)
            3'b000:  request_legal = 1'b1;
            3'b001:  request_legal = ~bus.reqAddress[0];
            3'b010:  request_legal = (bus.reqAddress[1:0] == 2'b00);
            3'b100:  request_legal = ~bus.reqStore;
            3'b101:  request_legal = ~bus.reqStore & ~bus.reqAddress[0];
            default: request_legal = 1'b0;
        endcase
    end

    // Store data is replicated over every lane so the memory only has to
    // honour byteEnable; the lane select comes from the low address bits.
    always_comb begin
        lane_data   = bus.reqData;
        lane_enable = 4'b1111;
        case (bus.reqFunct3[1:0])
            2'b00: begin
                lane_data   = {4{bus.reqData[7:0]}};
                lane_enable = 4'b0001 << bus.reqAddress[1:0];
            end
            2'b01: begin
                lane_data   = {2{bus.reqData[15:0]}};
                lane_enable = 4'b0011 << {bus.reqAddress[1], 1'b0};
            end
            default: begin
                lane_data   = bus.reqData;
                lane_enable = 4'b1111;
            end
        endcase
    end

    // Load extraction: bring the addressed byte/half down to bit 0, then
    // sign- or zero-extend according to the registered width code.
    always_comb begin
        load_shifted = bus.loadData >> {req_offset, 3'b000};
        case (req_funct3)
            3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_result = {24'h0, load_shifted[7:0]};
            3'b101:  load_result = {16'h0, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

    // Main FSM. All bus outputs except reqReady are registered here; the
    // async reset drops storeValid/byteEnable immediately and discards any
    // transaction in flight without a response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_funct3     <= 3'b000;
            req_offset     <= 2'b00;
            wait_count     <= '0;
            bus.respValid  <= 1'b0;
            bus.respFault  <= 1'b0;
            bus.respData   <= 32'h0;
            bus.address    <= 32'h0;
            bus.storeData  <= 32'h0;
            bus.byteEnable <= 4'b0000;
            bus.storeValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!request_legal) begin
                            // Faulting requests never touch the memory bus.
                            bus.respValid <= 1'b1;
                            bus.respFault <= 1'b1;
                            bus.respData  <= 32'h0;
                            state         <= RESP;
                        end else begin
                            bus.address <= {bus.reqAddress[31:2], 2'b00};
                            req_funct3  <= bus.reqFunct3;
                            req_offset  <= bus.reqAddress[1:0];
                            wait_count  <= '0;
                            if (bus.reqStore) begin
                                bus.storeData  <= lane_data;
                                bus.byteEnable <= lane_enable;
                                bus.storeValid <= 1'b1;
                                state          <= STORE_ISSUE;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (bus.loadDataValid) begin
                        bus.respValid <= 1'b1;
                        bus.respFault <= 1'b0;
                        bus.respData  <= load_result;
                        state         <= RESP;
                    end else if (wait_count == WAIT_LAST) begin
                        bus.respValid <= 1'b1;
                        bus.respFault <= 1'b1;
                        bus.respData  <= 32'h0;
                        state         <= RESP;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                STORE_ISSUE: begin
                    bus.storeValid <= 1'b0;
                    wait_count     <= '0;
                    state          <= STORE_WAIT;
                end
                STORE_WAIT: begin
                    if (bus.storeComplete) begin
                        bus.respValid  <= 1'b1;
                        bus.respFault  <= 1'b0;
                        bus.respData   <= 32'h0;
                        bus.byteEnable <= 4'b0000;
                        state          <= RESP;
                    end else if (wait_count == WAIT_LAST) begin
                        bus.respValid  <= 1'b1;
                        bus.respFault  <= 1'b1;
                        bus.respData   <= 32'h0;
                        bus.byteEnable <= 4'b0000;
                        state          <= RESP;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                RESP: begin
                    bus.respValid <= 1'b0;
                    bus.respFault <= 1'b0;
                    bus.respData  <= 32'h0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed, table-driven bench for load_store_unit with a small byte-lane
// data memory that acknowledges stores one cycle after taking them.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clock;
    logic reset;
    logic ack_enable;
    int   errors;
    int   checks;

    logic [31:0] mem [0:255];

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational word read of the current memory address.
    assign bus.loadData = mem[bus.address[9:2]];

    // Memory takes a store on the clock edge that sees storeValid and
    // reports completion with a registered pulse in the following cycle.
    always @(posedge clock) begin
        bus.storeComplete <= 1'b0;
        if (bus.storeValid && ack_enable) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteEnable[i]) begin
                    mem[bus.address[9:2]][8*i +: 8] <= bus.storeData[8*i +: 8];
                end
            end
            bus.storeComplete <= 1'b1;
        end
    end

    typedef struct {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ld_valid;
        logic        ack;
        int          exp_lat;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        int          exp_sv;
        logic [3:0]  exp_be;
        logic [31:0] exp_sd;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [20];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request, then observes the bus once per cycle until the
    // response arrives (bounded), counting latency in cycles after accept.
    task automatic applyStimulus(input vec_t v, output int lat, output int sv,
                                 output logic [3:0] be, output logic [31:0] sd,
                                 output logic [31:0] rdata, output logic rfault,
                                 output logic [31:0] addr_seen);
        be = 4'b0; sd = 32'h0; rdata = 32'h0; rfault = 1'b0; sv = 0;
        bus.reqStore      = v.store;
        bus.reqFunct3     = v.funct3;
        bus.reqAddress    = v.addr;
        bus.reqData       = v.data;
        bus.loadDataValid = v.ld_valid;
        ack_enable        = v.ack;
        bus.reqValid      = 1'b1;
        @(posedge clock); #1;
        bus.reqValid = 1'b0;
        addr_seen = bus.address;
        lat = 1;
        while (lat < 40) begin
            if (bus.storeValid) begin
                sv++;
                be = bus.byteEnable;
                sd = bus.storeData;
            end
            if (bus.respValid) begin
                rdata  = bus.respData;
                rfault = bus.respFault;
                break;
            end
            @(posedge clock); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          sv;
        logic [3:0]  be;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        rfault;
        logic [31:0] addr_seen;
        logic        sv_seen;
        string       tag;

        errors = 0;
        checks = 0;
        ack_enable        = 1'b1;
        bus.reqValid      = 1'b0;
        bus.reqStore      = 1'b0;
        bus.reqFunct3     = 3'b000;
        bus.reqAddress    = 32'h0;
        bus.reqData       = 32'h0;
        bus.loadDataValid = 1'b1;
        reset             = 1'b0;

        //            st    f3      addr        data        ld    ack  lat flt  rdata        sv be       sd           addr
        vecs[0]  = '{1'b1, 3'b010, 32'h200, 32'h80FF7F01, 1'b1, 1'b1, 3, 1'b0, 32'h0,        1, 4'b1111, 32'h80FF7F01, 32'h200};
        vecs[1]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 3, 1'b0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h100};
        vecs[2]  = '{1'b0, 3'b000, 32'h203, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'hFFFFFF80, 0, 4'b0000, 32'h0,        32'h200};
        vecs[3]  = '{1'b0, 3'b100, 32'h203, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'h00000080, 0, 4'b0000, 32'h0,        32'h200};
        vecs[4]  = '{1'b0, 3'b001, 32'h202, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'hFFFF80FF, 0, 4'b0000, 32'h0,        32'h200};
        vecs[5]  = '{1'b0, 3'b010, 32'h200, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'h80FF7F01, 0, 4'b0000, 32'h0,        32'h200};
        vecs[6]  = '{1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1'b1, 1'b1, 3, 1'b0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h100};
        vecs[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'hABCDBEEF, 0, 4'b0000, 32'h0,        32'h100};
        vecs[8]  = '{1'b0, 3'b010, 32'h101, 32'h0,        1'b1, 1'b1, 1, 1'b1, 32'h0,        0, 4'b0000, 32'h0,        32'h100};
        vecs[9]  = '{1'b1, 3'b001, 32'h103, 32'h1234,     1'b1, 1'b1, 1, 1'b1, 32'h0,        0, 4'b0000, 32'h0,        32'h100};
        vecs[10] = '{1'b0, 3'b011, 32'h104, 32'h0,        1'b1, 1'b1, 1, 1'b1, 32'h0,        0, 4'b0000, 32'h0,        32'h100};
        vecs[11] = '{1'b1, 3'b000, 32'h101, 32'h12345677, 1'b1, 1'b1, 3, 1'b0, 32'h0,        1, 4'b0010, 32'h77777777, 32'h100};
        vecs[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'hABCD77EF, 0, 4'b0000, 32'h0,        32'h100};
        vecs[13] = '{1'b0, 3'b101, 32'h202, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'h000080FF, 0, 4'b0000, 32'h0,        32'h200};
        vecs[14] = '{1'b0, 3'b001, 32'h200, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'h00007F01, 0, 4'b0000, 32'h0,        32'h200};
        vecs[15] = '{1'b0, 3'b000, 32'h201, 32'h0,        1'b1, 1'b1, 2, 1'b0, 32'h0000007F, 0, 4'b0000, 32'h0,        32'h200};
        vecs[16] = '{1'b1, 3'b100, 32'h100, 32'h99,       1'b1, 1'b1, 1, 1'b1, 32'h0,        0, 4'b0000, 32'h0,        32'h200};
        vecs[17] = '{1'b0, 3'b101, 32'h203, 32'h0,        1'b1, 1'b1, 1, 1'b1, 32'h0,        0, 4'b0000, 32'h0,        32'h200};
        vecs[18] = '{1'b0, 3'b010, 32'h200, 32'h0,        1'b0, 1'b1, 17, 1'b1, 32'h0,       0, 4'b0000, 32'h0,        32'h200};
        vecs[19] = '{1'b1, 3'b010, 32'h104, 32'h11111111, 1'b1, 1'b0, 18, 1'b1, 32'h0,       1, 4'b1111, 32'h11111111, 32'h104};

        // Outputs while reset is held.
        #12;
        checkOutput("reset_reqReady",   32'(bus.reqReady),   32'h0);
        checkOutput("reset_respValid",  32'(bus.respValid),  32'h0);
        checkOutput("reset_respFault",  32'(bus.respFault),  32'h0);
        checkOutput("reset_respData",   bus.respData,        32'h0);
        checkOutput("reset_storeValid", 32'(bus.storeValid), 32'h0);
        checkOutput("reset_byteEnable", 32'(bus.byteEnable), 32'h0);
        checkOutput("reset_address",    bus.address,         32'h0);
        checkOutput("reset_storeData",  bus.storeData,       32'h0);

        @(posedge clock); #1;
        reset = 1'b1;
        #1;

        for (int i = 0; i < 20; i++) begin
            tag = $sformatf("v%0d", i);
            checkOutput({tag, "_ready"}, 32'(bus.reqReady), 32'h1);
            applyStimulus(vecs[i], lat, sv, be, sd, rdata, rfault, addr_seen);
            checkOutput({tag, "_latency"},    32'(lat),    32'(vecs[i].exp_lat));
            checkOutput({tag, "_fault"},      32'(rfault), 32'(vecs[i].exp_fault));
            checkOutput({tag, "_respData"},   rdata,       vecs[i].exp_rdata);
            checkOutput({tag, "_storePulses"}, 32'(sv),    32'(vecs[i].exp_sv));
            checkOutput({tag, "_address"},    addr_seen,   vecs[i].exp_addr);
            if (vecs[i].exp_sv > 0) begin
                checkOutput({tag, "_byteEnable"}, 32'(be), 32'(vecs[i].exp_be));
                checkOutput({tag, "_storeData"},  sd,      vecs[i].exp_sd);
            end
            @(posedge clock); #1;
            checkOutput({tag, "_afterResp"},
                        {26'h0, bus.respValid, bus.storeValid, bus.byteEnable}, 32'h0);
        end

        // Late loadDataValid, with a store request held on reqValid during
        // the wait that must be ignored.
        ack_enable        = 1'b1;
        bus.loadDataValid = 1'b0;
        bus.reqStore      = 1'b0;
        bus.reqFunct3     = 3'b010;
        bus.reqAddress    = 32'h200;
        bus.reqValid      = 1'b1;
        @(posedge clock); #1;
        bus.reqStore   = 1'b1;
        bus.reqAddress = 32'h100;
        bus.reqData    = 32'h55555555;
        sv_seen = bus.storeValid;
        @(posedge clock); #1;
        sv_seen |= bus.storeValid;
        checkOutput("late_wait2", 32'(bus.respValid), 32'h0);
        @(posedge clock); #1;
        sv_seen |= bus.storeValid;
        checkOutput("late_wait3", 32'(bus.respValid), 32'h0);
        bus.reqValid      = 1'b0;
        bus.loadDataValid = 1'b1;
        @(posedge clock); #1;
        sv_seen |= bus.storeValid;
        checkOutput("late_respValid", 32'(bus.respValid), 32'h1);
        checkOutput("late_respData",  bus.respData,       32'h80FF7F01);
        checkOutput("late_noStore",   32'(sv_seen),       32'h0);
        @(posedge clock); #1;

        // Reset pulsed while a store waits for completion.
        ack_enable     = 1'b0;
        bus.reqStore   = 1'b1;
        bus.reqFunct3  = 3'b010;
        bus.reqAddress = 32'h108;
        bus.reqData    = 32'hCAFEF00D;
        bus.reqValid   = 1'b1;
        @(posedge clock); #1;
        bus.reqValid = 1'b0;
        checkOutput("abort_issue", 32'(bus.storeValid), 32'h1);
        @(posedge clock); #1;
        checkOutput("abort_waitBE", 32'(bus.byteEnable), 32'hF);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_outputs",
                    {25'h0, bus.reqReady, bus.respValid, bus.storeValid, bus.byteEnable}, 32'h0);
        checkOutput("abort_address",   bus.address,   32'h0);
        checkOutput("abort_storeData", bus.storeData, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset      = 1'b1;
        ack_enable = 1'b1;
        #1;
        checkOutput("abort_readyAfter", 32'(bus.reqReady), 32'h1);

        // First accept in the first cycle after release; no stale response
        // from the aborted store may precede it.
        vecs[0] = '{1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 1'b1, 2, 1'b0, 32'h80FF7F01,
                    0, 4'b0000, 32'h0, 32'h200};
        applyStimulus(vecs[0], lat, sv, be, sd, rdata, rfault, addr_seen);
        checkOutput("postReset_latency",  32'(lat), 32'h2);
        checkOutput("postReset_respData", rdata,    32'h80FF7F01);
        checkOutput("postReset_fault",    32'(rfault), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
